// File: rtl/riscuin_pkg.sv
// Shared definitions for the RISCuin instruction fetch front end.
package riscuin_pkg;

  localparam int unsigned INSTR_ADDR_WIDTH_DEF = 10;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

  // Fixed-width pc field so the entry type serves any address width up to 32.
  localparam int unsigned PC_FIELD_W = 32;

  typedef struct packed {
    logic [PC_FIELD_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous storage FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetcher: credit-limited requests, in-order prefetch queue, redirect flush.
// Optional IFU_PERF_COUNT_EN adds perf_fetched / perf_flushed event counters.
module instr_fetch_unit
  import riscuin_pkg::*;
#(
  parameter int unsigned                 INSTR_ADDR_WIDTH = INSTR_ADDR_WIDTH_DEF,
  parameter int unsigned                 DEPTH            = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic                        imem_ack,
  input  logic                        imem_rvalid,
  input  logic [31:0]                 imem_rdata,
  output logic                        instr_valid,
  output logic [31:0]                 instr,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
  input  logic                        instr_ready,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  output logic                        pc_end
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_flushed
`endif
);

  localparam int unsigned AW = INSTR_ADDR_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PC_MAX = '1;
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rsp_pc_q, rsp_pc_d;
  logic          pc_end_q, pc_end_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          run_q;

  logic [CW-1:0]   occ;
  logic [CW+1:0]   credit_used;
  logic            fifo_empty;
  logic            issue, pop, push, rsp_drop;
  fetch_entry_t    push_entry, head;
  logic [PC_FIELD_W-1:0] unused_head_pc;

  // Discarded slots still hold credit until their stale response arrives.
  assign credit_used = (CW+2)'(occ) + (CW+2)'(outst_q) + (CW+2)'(discard_q);
  assign imem_req    = run_q && !pc_end_q && (credit_used < (CW+2)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req && imem_ack;

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign rsp_drop    = imem_rvalid && (discard_q != '0);
  assign push        = imem_rvalid && (discard_q == '0) && !redirect;

  assign push_entry = '{pc: PC_FIELD_W'(rsp_pc_q), instr: imem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (occ),
    .empty_o (fifo_empty)
  );

  assign unused_head_pc = head.pc;
  assign instr          = instr_valid ? head.instr : '0;
  assign instr_pc       = instr_valid ? head.pc[AW-1:0] : '0;
  assign pc_end         = pc_end_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pc_end_d   = pc_end_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      pc_end_d   = 1'b0;
      outst_d    = '0;
      // Everything memory still owes becomes stale, including this cycle's issue.
      discard_d  = discard_q + outst_q + CW'(issue) - CW'(imem_rvalid);
    end else begin
      if (issue) begin
        if (fetch_pc_q == PC_MAX) pc_end_d   = 1'b1;
        else                      fetch_pc_d = fetch_pc_q + PC_ONE;
      end
      outst_d   = outst_q + CW'(issue) - CW'(push);
      discard_d = discard_q - CW'(rsp_drop);
      if (push) rsp_pc_d = rsp_pc_q + PC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      pc_end_q   <= 1'b0;
      outst_q    <= '0;
      discard_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pc_end_q   <= pc_end_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
    end
  end

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;
  logic [CW:0] flush_n;

  always_comb begin
    flush_n = '0;
    if (redirect) flush_n = (CW+1)'(occ) - (CW+1)'(pop) + (CW+1)'(imem_rvalid);
    else          flush_n = (CW+1)'(rsp_drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(push);
      perf_flushed_q <= perf_flushed_q + 32'(flush_n);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a tagged-request reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int unsigned   AW       = 10;
  localparam int unsigned   DEPTH    = 4;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam logic [AW-1:0] PC_MAX   = '1;

  logic          clk = 1'b0;
  logic          rst, imem_req, imem_ack, imem_rvalid, instr_valid, instr_ready, redirect, pc_end;
  logic [AW-1:0] imem_addr, instr_pc, redirect_pc;
  logic [31:0]   imem_rdata, instr;
`ifdef IFU_PERF_COUNT_EN
  logic [31:0]   perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_ADDR_WIDTH (AW),
    .DEPTH            (DEPTH),
    .RESET_PC         (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc_end       (pc_end)
`ifdef IFU_PERF_COUNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  typedef struct { logic [AW-1:0] addr; bit stale; int unsigned due; } req_t;
  typedef struct { logic [AW-1:0] pc; logic [31:0] word; } ent_t;

  req_t inf[$];
  ent_t mq[$];
  logic [AW-1:0] m_pc;
  bit            m_end, m_run;
  int unsigned   cyc, lat, ack_pct, ready_pct, rv_pct, redir_pct;
  int unsigned   obs_issue, n_push_m, n_flush_m;
  bit            force_redir;
  logic [AW-1:0] force_pc;
  int            n_cmp = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_0000;
  endfunction

  // Compare outputs against the model, drive one cycle of stimulus, advance the model.
  task automatic one_cycle();
    bit exp_req, do_rv, ack, rdy, redir, issue;
    logic [AW-1:0] rpc;
    req_t r;
    exp_req = m_run && !m_end && ((mq.size() + inf.size()) < DEPTH);
    n_cmp++;
    if (imem_req !== exp_req) begin n_fail++; $display("FAIL imem_req cyc %0d: got %b want %b", cyc, imem_req, exp_req); end
    if (exp_req) begin
      n_cmp++;
      if (imem_addr !== m_pc) begin n_fail++; $display("FAIL imem_addr cyc %0d: got %0h want %0h", cyc, imem_addr, m_pc); end
    end
    n_cmp++;
    if (instr_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL instr_valid cyc %0d: got %b want %b", cyc, instr_valid, mq.size() > 0); end
    if (mq.size() > 0) begin
      n_cmp += 2;
      if (instr_pc !== mq[0].pc) begin n_fail++; $display("FAIL instr_pc cyc %0d: got %0h want %0h", cyc, instr_pc, mq[0].pc); end
      if (instr !== mq[0].word) begin n_fail++; $display("FAIL instr cyc %0d: got %h want %h", cyc, instr, mq[0].word); end
    end
    n_cmp++;
    if (pc_end !== m_end) begin n_fail++; $display("FAIL pc_end cyc %0d: got %b want %b", cyc, pc_end, m_end); end
`ifdef IFU_PERF_COUNT_EN
    n_cmp += 2;
    if (perf_fetched !== n_push_m) begin n_fail++; $display("FAIL perf_fetched cyc %0d: got %0d want %0d", cyc, perf_fetched, n_push_m); end
    if (perf_flushed !== n_flush_m) begin n_fail++; $display("FAIL perf_flushed cyc %0d: got %0d want %0d", cyc, perf_flushed, n_flush_m); end
`endif
    if (imem_req === 1'b1 && imem_ack === 1'b1) obs_issue++;

    ack   = ($urandom_range(99) < ack_pct);
    rdy   = ($urandom_range(99) < ready_pct);
    do_rv = 1'b0;
    if (inf.size() > 0)
      if (inf[0].due <= cyc) do_rv = ($urandom_range(99) < rv_pct);
    redir = force_redir || ($urandom_range(99) < redir_pct);
    rpc   = force_redir ? force_pc : AW'($urandom);
    imem_ack    = ack;
    instr_ready = rdy;
    imem_rvalid = do_rv;
    imem_rdata  = do_rv ? mem_word(inf[0].addr) : $urandom;
    redirect    = redir;
    redirect_pc = rpc;

    @(posedge clk);
    issue = exp_req && ack;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (do_rv) begin
      r = inf.pop_front();
      if (r.stale || redir) n_flush_m++;
      else begin mq.push_back('{pc: r.addr, word: mem_word(r.addr)}); n_push_m++; end
    end
    if (issue) begin
      inf.push_back('{addr: m_pc, stale: 1'b0, due: cyc + lat});
      if (m_pc == PC_MAX) m_end = 1'b1;
      else                m_pc  = m_pc + AW'(1);
    end
    if (redir) begin
      n_flush_m += mq.size();
      mq.delete();
      foreach (inf[i]) inf[i].stale = 1'b1;
      m_pc  = rpc;
      m_end = 1'b0;
    end
    m_run = 1'b1;
    cyc++;
    force_redir = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; force_redir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 6;
    if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr: got %0h want %0h", imem_addr, RESET_PC); end
    if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (instr !== 32'h0)        begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (instr_pc !== '0)        begin n_fail++; $display("FAIL rst_instr_pc: got %0h want 0", instr_pc); end
    if (pc_end !== 1'b0)        begin n_fail++; $display("FAIL rst_pc_end: got %b want 0", pc_end); end
`ifdef IFU_PERF_COUNT_EN
    n_cmp += 2;
    if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL rst_perf_fetched: got %0d want 0", perf_fetched); end
    if (perf_flushed !== 32'h0) begin n_fail++; $display("FAIL rst_perf_flushed: got %0d want 0", perf_flushed); end
`endif
    inf.delete(); mq.delete();
    m_pc = RESET_PC; m_end = 1'b0; m_run = 1'b0; n_push_m = 0; n_flush_m = 0;
    rst = 1'b0;
  endtask

  task automatic set_knobs(input int unsigned l, input int unsigned a, input int unsigned r,
                           input int unsigned v, input int unsigned d);
    lat = l; ack_pct = a; ready_pct = r; rv_pct = v; redir_pct = d;
  endtask

  task automatic wait_valid_pc(input string name, input logic [AW-1:0] want);
    int unsigned n = 0;
    while (instr_valid !== 1'b1 && n < 30) begin one_cycle(); n++; end
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== want) begin
      n_fail++; $display("FAIL %s: got valid %b pc %0h want pc %0h", name, instr_valid, instr_pc, want);
    end
  endtask

  task automatic test_reset();
    set_knobs(1, 0, 0, 0, 0);
    do_reset();
    repeat (3) one_cycle();
  endtask

  task automatic test_stream();
    set_knobs(1, 100, 100, 100, 0);
    do_reset();
    repeat (3) one_cycle();
    n_cmp += 2;
    if (instr_valid !== 1'b1)  begin n_fail++; $display("FAIL stream_first_valid: got %b want 1", instr_valid); end
    if (instr_pc !== RESET_PC) begin n_fail++; $display("FAIL stream_first_pc: got %0h want %0h", instr_pc, RESET_PC); end
    for (int i = 0; i < 20; i++) begin
      one_cycle();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(i + 1)) begin
        n_fail++; $display("FAIL stream_pc_seq %0d: got valid %b pc %0h want pc %0h", i, instr_valid, instr_pc, AW'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned base;
    set_knobs(1, 100, 0, 100, 0);
    do_reset();
    base = obs_issue;
    repeat (20) one_cycle();
    n_cmp += 3;
    if (obs_issue - base != DEPTH) begin n_fail++; $display("FAIL bp_issues: got %0d want %0d", obs_issue - base, DEPTH); end
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL bp_req_low: got %b want 0", imem_req); end
    if (instr_pc !== RESET_PC) begin n_fail++; $display("FAIL bp_head_pc: got %0h want %0h", instr_pc, RESET_PC); end
  endtask

  task automatic test_redirect_drop();
    int unsigned n = 0;
    set_knobs(3, 100, 100, 100, 0);
    do_reset();
    while (inf.size() < 3 && n < 20) begin one_cycle(); n++; end
    n_cmp++;
    if (inf.size() < 3) begin n_fail++; $display("FAIL rd_outstanding: got %0d want 3", inf.size()); end
    force_redir = 1'b1; force_pc = AW'('h40);
    one_cycle();
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_low: got %b want 0", instr_valid); end
    wait_valid_pc("rd_first_pc", AW'('h40));
    repeat (10) one_cycle();
  endtask

  task automatic test_redirect_same_cycle();
    logic [AW-1:0] p;
    set_knobs(1, 100, 100, 100, 0);
    do_reset();
    repeat (6) one_cycle();
    for (int k = 0; k < 5; k++) begin
      p = AW'($urandom_range(0, (1 << AW) - 8));
      force_redir = 1'b1; force_pc = p;
      one_cycle();
      wait_valid_pc("rsc_first_pc", p);
      repeat (4) one_cycle();
    end
  endtask

  task automatic test_pc_end();
    set_knobs(1, 100, 100, 100, 0);
    do_reset();
    repeat (4) one_cycle();
    force_redir = 1'b1; force_pc = PC_MAX - AW'(1);
    one_cycle();
    wait_valid_pc("pe_first_pc", PC_MAX - AW'(1));
    one_cycle();
    n_cmp++;
    if (instr_pc !== PC_MAX) begin n_fail++; $display("FAIL pe_second_pc: got %0h want %0h", instr_pc, PC_MAX); end
    repeat (6) one_cycle();
    n_cmp += 2;
    if (pc_end !== 1'b1)   begin n_fail++; $display("FAIL pe_set: got %b want 1", pc_end); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL pe_req_low: got %b want 0", imem_req); end
    force_redir = 1'b1; force_pc = '0;
    one_cycle();
    n_cmp += 3;
    if (pc_end !== 1'b0)   begin n_fail++; $display("FAIL pe_clear: got %b want 0", pc_end); end
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL pe_resume_req: got %b want 1", imem_req); end
    if (imem_addr !== '0)  begin n_fail++; $display("FAIL pe_resume_addr: got %0h want 0", imem_addr); end
    repeat (6) one_cycle();
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      set_knobs($urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(40, 100), 5);
      do_reset();
      repeat (400) one_cycle();
    end
  endtask

  initial begin
    cyc = 0; obs_issue = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_pc_end();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
